// File: rtl/key_pkg.sv
// Shared types and constants for the push-button debouncer.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        DOWN       = 2'd2,
        REL_FILT   = 2'd3
    } key_state_e;

    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

    localparam int CNT_MAX_50MHZ_20MS = 1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= RST_VAL;
            q  <= RST_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/key_filter.sv
// Active-low push-button debouncer: clean level plus one-cycle
// press and release strobes, all registered.
module key_filter
    import key_pkg::*;
#(
    parameter int CNT_MAX = CNT_MAX_50MHZ_20MS,
    parameter int CNT_W   = $clog2(CNT_MAX)
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_state,
    output logic key_press_flag,
    output logic key_release_flag
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic             key_sync;
    logic [CNT_W-1:0] cnt;
    key_state_e       state;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (key_in),
        .q     (key_sync)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            key_state        <= KEY_RELEASED;
            key_press_flag   <= 1'b0;
            key_release_flag <= 1'b0;
        end else begin
            key_press_flag   <= 1'b0;
            key_release_flag <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (key_sync == KEY_PRESSED)
                        state <= PRESS_FILT;
                end
                PRESS_FILT: begin
                    if (key_sync == KEY_RELEASED) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state          <= DOWN;
                        cnt            <= '0;
                        key_state      <= KEY_PRESSED;
                        key_press_flag <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DOWN: begin
                    cnt <= '0;
                    if (key_sync == KEY_RELEASED)
                        state <= REL_FILT;
                end
                REL_FILT: begin
                    if (key_sync == KEY_PRESSED) begin
                        state <= DOWN;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state            <= IDLE;
                        cnt              <= '0;
                        key_state        <= KEY_RELEASED;
                        key_release_flag <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // Unreachable encodings fall back to a released key.
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    key_state <= KEY_RELEASED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_filter.sv
// Self-checking bench for key_filter with CNT_MAX = 4.
module tb_key_filter;

    localparam int CNT_MAX = 4;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic key_in = 1'b1;
    logic key_state;
    logic key_press_flag;
    logic key_release_flag;

    int vecs = 0;
    int errs = 0;
    int n_press = 0;
    int n_rel = 0;

    key_filter #(.CNT_MAX(CNT_MAX)) dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .key_in           (key_in),
        .key_state        (key_state),
        .key_press_flag   (key_press_flag),
        .key_release_flag (key_release_flag)
    );

    always #5 sys_clk = ~sys_clk;

    // Model: the debounced level flips once the synchronized pin has
    // disagreed with it on CNT_MAX+1 consecutive edges.
    bit h1, h2, m_lvl, m_pf, m_rf;
    int run;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h1 = 1; h2 = 1; m_lvl = 1; m_pf = 0; m_rf = 0; run = 0;
        end else begin
            bit s;
            s = h2;
            h2 = h1;
            h1 = key_in;
            m_pf = 0;
            m_rf = 0;
            if (s != m_lvl) begin
                run++;
                if (run == CNT_MAX + 1) begin
                    m_lvl = s;
                    run = 0;
                    if (s == 1'b0) m_pf = 1; else m_rf = 1;
                end
            end else begin
                run = 0;
            end
        end
    end

    always @(negedge sys_clk) begin
        vecs++;
        if (key_state !== m_lvl || key_press_flag !== m_pf ||
            key_release_flag !== m_rf) begin
            errs++;
            $display("FAIL model t=%0t got st/pf/rf=%b%b%b want %b%b%b",
                     $time, key_state, key_press_flag, key_release_flag,
                     m_lvl, m_pf, m_rf);
        end
        if (key_press_flag === 1'b1) n_press++;
        if (key_release_flag === 1'b1) n_rel++;
    end

    task automatic check(input string name, input int got, input int want);
        vecs++;
        if (got != want) begin
            errs++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic hold(input logic v, input int n);
        key_in = v;
        repeat (n) @(negedge sys_clk);
    endtask

    int p0, r0;

    initial begin
        repeat (3) @(negedge sys_clk);
        check("rst_state", key_state, 1);
        check("rst_pf", key_press_flag, 0);
        sys_rst_n = 1'b1;

        p0 = n_press; r0 = n_rel;
        hold(1'b1, 50);
        check("idle_press", n_press - p0, 0);
        check("idle_rel", n_rel - r0, 0);
        check("idle_state", key_state, 1);

        // Press latency: flag exactly after edge 6.
        key_in = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            @(negedge sys_clk);
            check($sformatf("press_pf_e%0d", i), key_press_flag, i == 6);
            check($sformatf("press_st_e%0d", i), key_state, i >= 6 ? 0 : 1);
        end
        hold(1'b0, 4);

        // Release latency, symmetric.
        key_in = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            @(negedge sys_clk);
            check($sformatf("rel_rf_e%0d", i), key_release_flag, i == 6);
            check($sformatf("rel_st_e%0d", i), key_state, i >= 6 ? 1 : 0);
        end
        hold(1'b1, 4);

        // Bouncy press never qualifies.
        p0 = n_press;
        hold(1'b0, 3);
        hold(1'b1, 1);
        hold(1'b0, 2);
        hold(1'b1, 12);
        check("bounce_press", n_press - p0, 0);
        check("bounce_state", key_state, 1);
        hold(1'b0, 10);
        check("press_after_bounce", n_press - p0, 1);
        check("down_state", key_state, 0);

        // Short high glitch while down.
        r0 = n_rel;
        hold(1'b1, 2);
        hold(1'b0, 8);
        check("down_glitch_rel", n_rel - r0, 0);
        check("down_glitch_st", key_state, 0);
        hold(1'b1, 10);
        check("release_after_glitch", n_rel - r0, 1);

        // Async reset in the middle of press filtering (cnt = 2).
        key_in = 1'b0;
        repeat (5) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_rst_state", key_state, 1);
        check("async_rst_pf", key_press_flag, 0);
        check("async_rst_rf", key_release_flag, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i <= 7; i++) begin
            @(negedge sys_clk);
            check($sformatf("rq_pf_e%0d", i), key_press_flag, i == 6);
        end
        hold(1'b1, 12);

        // Single-cycle glitches at spacing below CNT_MAX.
        p0 = n_press; r0 = n_rel;
        for (int k = 0; k < 100; k++) begin
            hold(1'b0, 1);
            hold(1'b1, $urandom_range(1, 3));
        end
        hold(1'b1, 10);
        check("glitch_press", n_press - p0, 0);
        check("glitch_rel", n_rel - r0, 0);

        // Full press/release leaves counts balanced.
        hold(1'b0, 12);
        hold(1'b1, 12);
        check("balance", n_press, n_rel);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/key_filter.md
Name: key_filter

Overview:
- Debounces one raw, active-low mechanical push-button and produces clean events.
- Sits between the board key pin and downstream registered consumers (LED latch/toggle logic), which see a clean level plus one-cycle press/release strobes instead of the raw bouncing pin.
- Contains a 2-FF synchronizer, a stability counter and a 4-state FSM.

Parameters:
- CNT_MAX, default 1_000_000: number of consecutive stable cycles required to accept a transition (20 ms at 50 MHz). Legal range is ≥ 2; the bench uses 4.
- CNT_W, default $clog2(CNT_MAX): counter width (derived, not overridden).

Ports:
- sys_clk  in  1  single system clock, rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset; removal is synchronous to sys_clk upstream.
- key_in  in  1  raw button pin, asynchronous to sys_clk; 0 = pressed.
- key_state  out  1  debounced level; 0 = pressed, 1 = released.
- key_press_flag  out  1  one-cycle strobe when a press is accepted.
- key_release_flag  out  1  one-cycle strobe when a release is accepted.

Behaviour:
- Clock and reset: one clock (sys_clk). Reset is asynchronous and active-low (sys_rst_n); every flop is in reset while sys_rst_n = 0.
- Reset values: sync flops = 1, cnt = 0, state = IDLE, key_state = 1, both flags = 0.
- Synchronizer: key_in → s1 → s2. key_sync = s2. Only key_sync feeds the FSM.
- All outputs are registered; there is no combinational path from key_in to any output.
- FSM, evaluated every rising edge:
  - IDLE (released, stable):
    - key_sync = 0 → PRESS_FILT, cnt ← 0.
    - Else stay.
  - PRESS_FILT:
    - key_sync = 1 → IDLE, cnt ← 0. This is a bounce: no flag, key_state unchanged.
    - Else if cnt = CNT_MAX-1 → DOWN, key_state ← 0, key_press_flag ← 1 for exactly one cycle.
    - Else cnt ← cnt+1.
  - DOWN (pressed, stable):
    - key_sync = 1 → REL_FILT, cnt ← 0.
    - Else stay.
  - REL_FILT:
    - key_sync = 0 → DOWN, cnt ← 0. No flag.
    - Else if cnt = CNT_MAX-1 → IDLE, key_state ← 1, key_release_flag ← 1 for exactly one cycle.
    - Else cnt ← cnt+1.
- Flags default to 0 every cycle. They never assert together or on consecutive cycles. They never assert while in reset.
- Latency: edge 0 is the first edge that samples key_in = 0 and it stays low. key_press_flag and key_state fall are visible after edge CNT_MAX+2:
  - 2 edges in the synchronizer.
  - 1 edge for the IDLE → PRESS_FILT transition.
  - CNT_MAX-1 further edges of counting.
  - Release is symmetric.
- Minimum accepted pulse: key_sync must hold for CNT_MAX consecutive cycles inside the filter state. Any glitch shorter than that produces no flag.
- Counter: saturating behaviour is never reached because cnt is cleared on every exit. In IDLE and DOWN, cnt is held at 0.
- Reset mid-filter: the FSM returns to IDLE with key_state = 1 even if the button is physically held. After reset release, a held key is re-qualified as a new press, giving a flag after CNT_MAX+2 edges.
- Illegal state encodings recover to IDLE (default branch).

Decomposition:
- Shared package key_pkg:
  - State enum IDLE / PRESS_FILT / DOWN / REL_FILT, 2-bit encoding.
  - KEY_PRESSED = 1'b0 and KEY_RELEASED = 1'b1 constants.
  - Default CNT_MAX_50MHZ_20MS = 1_000_000.
- One natural sub-module: sync_2ff (parameterizable reset value, here 1), reusable for other asynchronous pins.

Test Plan:
- Reset, then hold key_in = 1 for 50 cycles → key_state = 1 and both flags 0 throughout.
- CNT_MAX = 4: key_in drops to 0, sampled at edge 0, then held → key_press_flag = 1 only between edges 6 and 7, and key_state = 0 from edge 6 onward.
- Bounce on press: key_in 0 for 3 cycles, 1 for 1 cycle, 0 for 2 cycles, 1 thereafter → no flag, key_state stays 1. Then 0 for 10 cycles → exactly one press flag.
- Release from DOWN: key_in goes to 1 and is held → key_release_flag single pulse 6 edges after first sampling, key_state = 1. A 2-cycle high glitch while DOWN gives no release flag.
- Reset asserted asynchronously mid-PRESS_FILT with cnt = 2 → outputs return to reset values immediately, without waiting for a clock edge. With key still held after release → press flag at edge 6 after reset deassertion.
- 1-cycle random glitches on key_in (100 events, spacing < 4 cycles) → zero flags. Press-flag count equals release-flag count over a full press/release sequence.
